noc_router_arb_ctrl: RTL and testbench
======================================

NOC_ROUTER_ARB_CTRL -- requirements
Module: noc_router_arb_ctrl

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of input ports and output ports.
REQ-002 SHALL have parameter PORT_W, default 2: port index width; NUM_PORTS == 2**PORT_W is required.
REQ-003 SHALL have parameter STALL_MAX, default 15: maximum ROUTE stall cycles before a packet is dropped; 1..255.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port valid_in, input, NUM_PORTS bits: per-input-port packet request.
REQ-007 SHALL have port dest_in, input, NUM_PORTS*PORT_W bits: per-port destination; port i occupies bits [i*PORT_W +: PORT_W].
REQ-008 SHALL have port buf_full, input, NUM_PORTS bits: per-output-buffer full flag.
REQ-009 SHALL have port ready_out, output, NUM_PORTS bits: per-input-port accept strobe.
REQ-010 SHALL have port buffer_enable, output, 1 bit: write strobe to the output buffer selected by out_sel.
REQ-011 SHALL have port in_sel, output, PORT_W bits: index of the granted input port.
REQ-012 SHALL have port out_sel, output, PORT_W bits: index of the destination output port.
REQ-013 SHALL have port drop, output, 1 bit: one-cycle pulse when a packet is discarded on timeout.
REQ-014 SHALL have port pkt_count, output, 16 bits: count of buffered packets, saturating.
REQ-015 SHALL have port drop_count, output, 8 bits: count of dropped packets, saturating.

Function
REQ-016 SHALL implement the states IDLE, RECEIVE, ROUTE and BUFFER; any illegal encoding SHALL go to IDLE.
REQ-017 In IDLE with any valid_in bit set, SHALL grant round-robin, searching from rr_ptr upward modulo NUM_PORTS; SHALL latch the winner index into in_sel and that port's dest_in into out_sel; next state RECEIVE.
REQ-018 In IDLE with valid_in == 0, SHALL stay in IDLE and hold in_sel, out_sel and rr_ptr.
REQ-019 In RECEIVE, SHALL drive ready_out[in_sel] = 1 for exactly one cycle, with all other ready_out bits 0; next state ROUTE unconditionally.
REQ-020 The transfer SHALL be defined as valid_in[i] && ready_out[i]; the source SHALL hold valid_in and dest_in stable from the IDLE sample through RECEIVE; the controller SHALL NOT recheck valid_in in RECEIVE.
REQ-021 In ROUTE, when buf_full[out_sel] == 0, SHALL go to BUFFER next and clear the stall counter.
REQ-022 In ROUTE, when buf_full[out_sel] == 1, SHALL stay in ROUTE and increment an 8-bit stall counter.
REQ-023 When the stall counter reaches STALL_MAX with buf_full still set, SHALL pulse drop for 1 cycle, increment drop_count (saturating at 255), clear the stall counter, advance rr_ptr, and go to IDLE.
REQ-024 In BUFFER, SHALL drive buffer_enable = 1 for exactly one cycle, increment pkt_count (saturating at 16'hFFFF), set rr_ptr = (in_sel + 1) mod NUM_PORTS, and go to IDLE.
REQ-025 All outputs except in_sel, out_sel, pkt_count and drop_count SHALL be Moore outputs decoded from the current state.
REQ-026 Unstalled latency SHALL be: request sampled in IDLE at cycle 0, ready_out at cycle 1, buffer_enable at cycle 3, back in IDLE at cycle 4; minimum spacing between grants is 4 cycles.
REQ-027 In_sel and out_sel SHALL be stable from RECEIVE through BUFFER.
REQ-028 A buf_full deassertion in the same cycle as the stall counter reaching STALL_MAX SHALL win: go to BUFFER, no drop.

Reset
REQ-029 Asserting reset SHALL immediately force state = IDLE, ready_out = 0, buffer_enable = 0, drop = 0, in_sel = 0, out_sel = 0, rr_ptr = 0, stall counter = 0, pkt_count = 0 and drop_count = 0.
REQ-030 Reset asserted mid-packet SHALL abandon the packet with no buffer_enable and no count update.
REQ-031 After reset deasserts, the first grant SHALL start searching from port 0.

Verification
REQ-032 Single request: valid_in = 4'b0100, dest[2] = 3 -> ready_out = 4'b0100 at cycle 1, buffer_enable with out_sel = 3 at cycle 3, pkt_count = 1.
REQ-033 Fairness: valid_in = 4'b1111 held for 16 cycles -> grants in order 0, 1, 2, 3, each port exactly once, pkt_count = 4.
REQ-034 Stall: buf_full[1] = 1 for 5 cycles with dest = 1 -> ROUTE held for 5 cycles, then buffer_enable once, drop never asserted.
REQ-035 Timeout: buf_full[2] held at 1 with STALL_MAX = 15 -> drop pulses once after 15 stall cycles, drop_count = 1, no buffer_enable, next grant goes to the following port.
REQ-036 Reset mid-ROUTE -> all outputs and counters are 0 immediately; the next request is granted from port 0.
REQ-037 Saturation: force 65540 packets -> pkt_count stays at 16'hFFFF.

Source files
------------

// File: rtl/noc_router_arb_ctrl.sv
// Round-robin grant controller for a NoC router: one packet in flight at a time,
// walking IDLE -> RECEIVE -> ROUTE (stall / timeout drop) -> BUFFER.
module noc_router_arb_ctrl #(
   parameter int NUM_PORTS = 4,
   parameter int PORT_W    = 2,
   parameter int STALL_MAX = 15
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_PORTS-1:0]        valid_in,
   input  logic [NUM_PORTS*PORT_W-1:0] dest_in,
   input  logic [NUM_PORTS-1:0]        buf_full,
   output logic [NUM_PORTS-1:0]        ready_out,
   output logic                        buffer_enable,
   output logic [PORT_W-1:0]           in_sel,
   output logic [PORT_W-1:0]           out_sel,
   output logic                        drop,
   output logic [15:0]                 pkt_count,
   output logic [7:0]                  drop_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RECEIVE = 2'd1,
      ROUTE   = 2'd2,
      BUFFER  = 2'd3
   } state_t;

   localparam logic [7:0] STALL_LIMIT = 8'(STALL_MAX);

   state_t            state_q, state_d;
   logic [PORT_W-1:0] in_sel_q, in_sel_d;
   logic [PORT_W-1:0] out_sel_q, out_sel_d;
   logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [7:0]        stall_q, stall_d;
   logic [15:0]       pkt_cnt_q, pkt_cnt_d;
   logic [7:0]        drop_cnt_q, drop_cnt_d;
   logic              drop_q, drop_d;

   logic              grant_found_s;
   logic [PORT_W-1:0] grant_idx_s;
   logic [PORT_W-1:0] cand_s;
   logic [PORT_W-1:0] next_ptr_s;

   // Round-robin search from rr_ptr upward; the adder wraps because NUM_PORTS == 2**PORT_W.
   always_comb begin
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      cand_s        = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         cand_s = rr_ptr_q + PORT_W'(k);
         if (!grant_found_s && valid_in[cand_s]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = cand_s;
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   assign next_ptr_s = in_sel_q + PORT_W'(1);

   // Next-state and counter update logic.
   always_comb begin
      state_d    = state_q;
      in_sel_d   = in_sel_q;
      out_sel_d  = out_sel_q;
      rr_ptr_d   = rr_ptr_q;
      stall_d    = stall_q;
      pkt_cnt_d  = pkt_cnt_q;
      drop_cnt_d = drop_cnt_q;
      drop_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_found_s) begin
               in_sel_d  = grant_idx_s;
               out_sel_d = dest_in[grant_idx_s*PORT_W +: PORT_W];
               state_d   = RECEIVE;
            end else begin
               state_d = IDLE;
            end
         end
         RECEIVE: begin
            state_d = ROUTE;
         end
         ROUTE: begin
            // A freed buffer wins over a timeout reached in the same cycle.
            if (!buf_full[out_sel_q]) begin
               stall_d = 8'd0;
               state_d = BUFFER;
            end else if (stall_q >= STALL_LIMIT) begin
               drop_d     = 1'b1;
               drop_cnt_d = (drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
               stall_d    = 8'd0;
               rr_ptr_d   = next_ptr_s;
               state_d    = IDLE;
            end else begin
               stall_d = stall_q + 8'd1;
            end
         end
         BUFFER: begin
            pkt_cnt_d = (pkt_cnt_q != 16'hFFFF) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
            rr_ptr_d  = next_ptr_s;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         in_sel_q   <= '0;
         out_sel_q  <= '0;
         rr_ptr_q   <= '0;
         stall_q    <= 8'd0;
         pkt_cnt_q  <= 16'd0;
         drop_cnt_q <= 8'd0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_sel_q   <= in_sel_d;
         out_sel_q  <= out_sel_d;
         rr_ptr_q   <= rr_ptr_d;
         stall_q    <= stall_d;
         pkt_cnt_q  <= pkt_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         drop_q     <= drop_d;
      end
   end

   // Strobes decoded from the registered state.
   always_comb begin
      if (state_q == RECEIVE) begin
         ready_out = {{(NUM_PORTS-1){1'b0}}, 1'b1} << in_sel_q;
      end else begin
         ready_out = '0;
      end
      buffer_enable = (state_q == BUFFER);
   end

   assign drop       = drop_q;
   assign in_sel     = in_sel_q;
   assign out_sel    = out_sel_q;
   assign pkt_count  = pkt_cnt_q;
   assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_noc_router_arb_ctrl.sv
// Directed bench for noc_router_arb_ctrl: vector table of single packets plus
// reset, fairness and counter-saturation sequences.
module tb_noc_router_arb_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] valid_in;
   logic [7:0] dest_in;
   logic [3:0] buf_full;
   logic [3:0] ready_out;
   logic       buffer_enable;
   logic [1:0] in_sel;
   logic [1:0] out_sel;
   logic       drop;
   logic [15:0] pkt_count;
   logic [7:0]  drop_count;

   int n_chk  = 0;
   int n_fail = 0;

   noc_router_arb_ctrl #(.NUM_PORTS(4), .PORT_W(2), .STALL_MAX(15)) dut (
      .clk           (clk),
      .reset         (reset),
      .valid_in      (valid_in),
      .dest_in       (dest_in),
      .buf_full      (buf_full),
      .ready_out     (ready_out),
      .buffer_enable (buffer_enable),
      .in_sel        (in_sel),
      .out_sel       (out_sel),
      .drop          (drop),
      .pkt_count     (pkt_count),
      .drop_count    (drop_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] v;
      logic [7:0] d;
      logic [3:0] bf;
      int         clr;    // tick after grant at which buf_full is released (0 = never)
      logic [3:0] e_rdy;
      logic [1:0] e_in;
      logic [1:0] e_out;
      int         e_be;   // ticks after the ready cycle to buffer_enable (-1 = none)
      int         e_dr;   // ticks after the ready cycle to drop (-1 = none)
   } vec_t;

   vec_t tbl [10];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " ready_out"}, 32'(ready_out), 32'd0);
      chk({tag, " buffer_enable"}, 32'(buffer_enable), 32'd0);
      chk({tag, " drop"}, 32'(drop), 32'd0);
      chk({tag, " in_sel"}, 32'(in_sel), 32'd0);
      chk({tag, " out_sel"}, 32'(out_sel), 32'd0);
      chk({tag, " pkt_count"}, 32'(pkt_count), 32'd0);
      chk({tag, " drop_count"}, 32'(drop_count), 32'd0);
   endtask

   // Issue one request and watch the following 40 cycles.
   task automatic run_pkt(input logic [3:0] v, input logic [7:0] d, input logic [3:0] bf,
                          input int clr, output logic [3:0] rdy, output logic [1:0] isel,
                          output logic [1:0] osel, output int be_at, output int be_n,
                          output logic [1:0] be_out, output int dr_at, output int dr_n);
      valid_in = v;
      dest_in  = d;
      buf_full = bf;
      tick;
      rdy  = ready_out;
      isel = in_sel;
      osel = out_sel;
      valid_in = 4'd0;
      be_at = -1; be_n = 0; dr_at = -1; dr_n = 0; be_out = 2'd0;
      for (int k = 1; k <= 40; k++) begin
         tick;
         if (buffer_enable) begin
            be_n++;
            if (be_at < 0) begin
               be_at  = k;
               be_out = out_sel;
            end
         end
         if (drop) begin
            dr_n++;
            if (dr_at < 0) dr_at = k;
         end
         if (k == clr) buf_full = 4'd0;
      end
      buf_full = 4'd0;
   endtask

   initial begin
      logic [3:0] rdy;
      logic [1:0] isel, osel, be_out;
      int be_at, be_n, dr_at, dr_n, ng;
      logic [1:0] gr [4];

      //           valid    dest    full     clr  rdy      in     out    be  drop
      tbl[0] = '{4'b0100, 8'h30, 4'b0000, 0,  4'b0100, 2'd2, 2'd3, 2,  -1};
      tbl[1] = '{4'b0011, 8'h09, 4'b0000, 0,  4'b0001, 2'd0, 2'd1, 2,  -1};
      tbl[2] = '{4'b0011, 8'h09, 4'b0000, 0,  4'b0010, 2'd1, 2'd2, 2,  -1};
      tbl[3] = '{4'b1001, 8'h02, 4'b0000, 0,  4'b1000, 2'd3, 2'd0, 2,  -1};
      tbl[4] = '{4'b1000, 8'h80, 4'b0000, 0,  4'b1000, 2'd3, 2'd2, 2,  -1};
      tbl[5] = '{4'b0001, 8'h03, 4'b0000, 0,  4'b0001, 2'd0, 2'd3, 2,  -1};
      tbl[6] = '{4'b0010, 8'h04, 4'b0010, 6,  4'b0010, 2'd1, 2'd1, 7,  -1};
      tbl[7] = '{4'b0100, 8'h20, 4'b0100, 16, 4'b0100, 2'd2, 2'd2, 17, -1};
      tbl[8] = '{4'b1000, 8'h40, 4'b0010, 0,  4'b1000, 2'd3, 2'd1, -1, 17};
      tbl[9] = '{4'b1001, 8'h02, 4'b0000, 0,  4'b0001, 2'd0, 2'd2, 2,  -1};

      reset = 1'b1; valid_in = 4'd0; dest_in = 8'd0; buf_full = 4'd0;
      tick; tick;
      chk_zero("reset");
      reset = 1'b0;
      tick;

      for (int i = 0; i < 10; i++) begin
         run_pkt(tbl[i].v, tbl[i].d, tbl[i].bf, tbl[i].clr, rdy, isel, osel,
                 be_at, be_n, be_out, dr_at, dr_n);
         chk($sformatf("v%0d ready_out", i), 32'(rdy), 32'(tbl[i].e_rdy));
         chk($sformatf("v%0d in_sel", i), 32'(isel), 32'(tbl[i].e_in));
         chk($sformatf("v%0d out_sel", i), 32'(osel), 32'(tbl[i].e_out));
         chk($sformatf("v%0d be_cycle", i), 32'(be_at), 32'(tbl[i].e_be));
         chk($sformatf("v%0d be_pulses", i), 32'(be_n), (tbl[i].e_be >= 0) ? 32'd1 : 32'd0);
         chk($sformatf("v%0d drop_cycle", i), 32'(dr_at), 32'(tbl[i].e_dr));
         chk($sformatf("v%0d drop_pulses", i), 32'(dr_n), (tbl[i].e_dr >= 0) ? 32'd1 : 32'd0);
         if (tbl[i].e_be >= 0) chk($sformatf("v%0d out_sel_at_be", i), 32'(be_out), 32'(tbl[i].e_out));
      end
      chk("table pkt_count", 32'(pkt_count), 32'd9);
      chk("table drop_count", 32'(drop_count), 32'd1);
      chk("idle hold in_sel", 32'(in_sel), 32'd0);
      chk("idle hold out_sel", 32'(out_sel), 32'd2);

      // Reset while stalled in ROUTE: port 2 granted, buffer full.
      valid_in = 4'b0100; dest_in = 8'h10; buf_full = 4'b0010;
      tick;
      chk("pre-reset ready_out", 32'(ready_out), 32'h4);
      valid_in = 4'd0;
      tick; tick;
      #2 reset = 1'b1;
      #1 chk_zero("mid-route reset");
      buf_full = 4'd0;
      tick;
      reset = 1'b0;
      tick;
      chk("post-reset buffer_enable", 32'(buffer_enable), 32'd0);
      chk("post-reset pkt_count", 32'(pkt_count), 32'd0);

      // Fairness: all ports requesting for 16 cycles.
      valid_in = 4'b1111; dest_in = 8'hE4;
      ng = 0;
      for (int k = 0; k < 16; k++) begin
         tick;
         if (ready_out != 4'd0) begin
            if (ng < 4) gr[ng] = in_sel;
            ng++;
         end
      end
      valid_in = 4'd0;
      chk("fair grant count", 32'(ng), 32'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("fair grant %0d", i), 32'(gr[i]), 32'(i));
      chk("fair pkt_count", 32'(pkt_count), 32'd4);

      // Saturation: preload the packet counter near its ceiling.
      tick;
      force dut.pkt_cnt_q = 16'hFFFD;
      tick;
      release dut.pkt_cnt_q;
      tick;
      for (int p = 0; p < 5; p++) begin
         run_pkt(4'b0001, 8'h01, 4'd0, 0, rdy, isel, osel, be_at, be_n, be_out, dr_at, dr_n);
         if (p == 0) chk("sat first increment", 32'(pkt_count), 32'hFFFE);
      end
      chk("sat pkt_count", 32'(pkt_count), 32'hFFFF);
      chk("sat drop_count", 32'(drop_count), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
